mul_div_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit for the Virgule core; the multi-cycle companion to the one-cycle ALU.
//   - Accepts one operation per start pulse and computes over 32 radix-2 steps (shift-add / restoring divide).
//   - Returns the result with a one-cycle done pulse.
//   - Sits beside the ALU in the execute stage; the control FSM stalls fetch while busy is high.

---
 rtl/mul_div_unit_pkg.sv | 42 ++++
 rtl/mul_div_unit_if.sv | 24 ++
 rtl/mul_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_div_unit_pkg                                                     |
// | Shared types for the iterative RV32M multiply/divide unit: operation |
// | encoding, machine word type, step count and small decode helpers.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mul_div_unit_pkg;

  // Number of radix-2 iterations for one operation
  localparam int MULDIV_STEPS = 32;

  typedef logic [31:0] word_t;

  // Encoding matches RV32M funct3 so the decoder can pass it straight through
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_fn_t;

  function automatic logic is_div_fn(input muldiv_fn_t fn);
    return fn[2];
  endfunction

  // rs1 is treated as signed for mulh, mulhsu, div and rem
  function automatic logic signed_rs1(input muldiv_fn_t fn);
    return (fn == MD_MULH) || (fn == MD_MULHSU) || (fn == MD_DIV) || (fn == MD_REM);
  endfunction

  // rs2 is treated as signed for mulh, div and rem
  function automatic logic signed_rs2(input muldiv_fn_t fn);
    return (fn == MD_MULH) || (fn == MD_DIV) || (fn == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_div_unit_if                                                      |
// | Request/response bundle between the execute stage and the mul/div    |
// | unit. master = requester, slave = mul_div_unit.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  muldiv_fn_t       fn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] r;

  modport master (output start, fn, a, b, input busy, done, r);
  modport slave  (input start, fn, a, b, output busy, done, r);
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_div_unit                                                         |
// | Iterative RV32M multiply/divide: 32 shift-add or restoring-divide    |
// | steps on magnitudes, then one sign-fix cycle and a done pulse.       |
// | Divide-by-zero and signed overflow finish immediately.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);

  generate
    if (WIDTH != $bits(word_t)) begin : g_width_check
      $error("mul_div_unit: WIDTH must equal the width of word_t");
    end
  endgenerate

  localparam int               c_cnt_w     = $clog2(MULDIV_STEPS);
  localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(MULDIV_STEPS - 1);
  localparam logic [WIDTH-1:0] c_int_min   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  muldiv_fn_t         r_fn;
  logic               r_negate;
  logic [c_cnt_w-1:0] r_count;
  // Shared datapath: {r_hi,r_lo} is product or {remainder,quotient};
  // r_opnd is the multiplicand or the divisor.
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opnd;

  // Request decode
  logic             w_neg_a, w_neg_b, w_is_div, w_is_rem;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic             w_div_zero, w_div_ovf;
  logic             w_negate;
  logic [WIDTH-1:0] w_special_r;

  assign w_neg_a    = signed_rs1(bus.fn) & bus.a[WIDTH-1];
  assign w_neg_b    = signed_rs2(bus.fn) & bus.b[WIDTH-1];
  assign w_abs_a    = w_neg_a ? -bus.a : bus.a;
  assign w_abs_b    = w_neg_b ? -bus.b : bus.b;
  assign w_is_div   = is_div_fn(bus.fn);
  assign w_is_rem   = (bus.fn == MD_REM) || (bus.fn == MD_REMU);
  assign w_div_zero = w_is_div && (bus.b == '0);
  assign w_div_ovf  = ((bus.fn == MD_DIV) || (bus.fn == MD_REM)) &&
                      (bus.a == c_int_min) && (bus.b == '1);

  // Which result needs negating after the magnitude computation
  always_comb begin
    w_negate = 1'b0;
    case (bus.fn)
      MD_MULH, MD_DIV:   w_negate = w_neg_a ^ w_neg_b;
      MD_MULHSU, MD_REM: w_negate = w_neg_a;
      default:           w_negate = 1'b0;
    endcase
  end

  // Immediate results for divide-by-zero and INT_MIN / -1
  always_comb begin
    w_special_r = '0;
    if (w_div_zero) begin
      w_special_r = w_is_rem ? bus.a : '1;
    end else begin
      w_special_r = w_is_rem ? '0 : c_int_min;
    end
  end

  // Multiply step: conditional add with carry, then shift {carry,hi,lo} right
  logic [WIDTH:0]   w_add, w_mul_acc;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
  assign w_add     = {1'b0, r_hi} + {1'b0, r_opnd};
  assign w_mul_acc = r_lo[0] ? w_add : {1'b0, r_hi};
  assign w_mul_hi  = w_mul_acc[WIDTH:1];
  assign w_mul_lo  = {w_mul_acc[0], r_lo[WIDTH-1:1]};

  // Divide step: shift {rem,quo} left, subtract divisor when it fits
  logic [WIDTH:0]   w_shift;
  logic             w_fits;
  logic [WIDTH-1:0] w_div_hi, w_div_lo;
  assign w_shift  = {r_hi, r_lo[WIDTH-1]};
  assign w_fits   = w_shift >= {1'b0, r_opnd};
  assign w_div_hi = w_fits ? (w_shift[WIDTH-1:0] - r_opnd) : w_shift[WIDTH-1:0];
  assign w_div_lo = {r_lo[WIDTH-2:0], w_fits};

  // Sign correction and half selection for the final result
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_result;
  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_negate ? -w_prod : w_prod;

  always_comb begin
    w_result = '0;
    case (r_fn)
      MD_MUL:                      w_result = w_prod_fix[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_result = w_prod_fix[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:             w_result = r_negate ? -r_lo : r_lo;
      MD_REM, MD_REMU:             w_result = r_negate ? -r_hi : r_hi;
      default:                     w_result = '0;
    endcase
  end

  // Control FSM and datapath registers; busy/done/r are registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_fn     <= MD_MUL;
      r_negate <= 1'b0;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.r    <= '0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            r_fn     <= bus.fn;
            r_negate <= w_negate;
            r_count  <= '0;
            if (w_div_zero || w_div_ovf) begin
              bus.r    <= w_special_r;
              bus.done <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_is_div ? w_abs_a : w_abs_b;
              r_opnd  <= w_is_div ? w_abs_b : w_abs_a;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (is_div_fn(r_fn)) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
          end else begin
            r_hi <= w_mul_hi;
            r_lo <= w_mul_lo;
          end
          r_count <= r_count + 1'b1;
          if (r_count == c_last_step) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          bus.r    <= w_result;
          bus.done <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_mul_div_unit                                                      |
// | Table-driven and scoreboard bench for mul_div_unit: results and      |
// | latency checked against constants and an independent 64-bit model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;

  logic [31:0] cur_exp = '0;
  int          cur_lat = 0;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          start_cyc;
  } sb_t;
  sb_t sbq[$];
  int  done_cycs[$];

  typedef struct {
    muldiv_fn_t  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle index; cycle k ends at rising edge k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference RV32M behaviour from wide native arithmetic
  function automatic logic [31:0] ref_op(input muldiv_fn_t f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, sp;
    logic [63:0] ux, uy, up;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (f)
      MD_MUL:    begin up = ux * uy; return up[31:0]; end
      MD_MULH:   begin sp = sx * sy; return sp[63:32]; end
      MD_MULHSU: begin sp = sx * $signed(uy); return sp[63:32]; end
      MD_MULHU:  begin up = ux * uy; return up[63:32]; end
      MD_DIV: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sx / sy; return sp[31:0];
      end
      MD_DIVU: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        up = ux / uy; return up[31:0];
      end
      MD_REM: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        sp = sx % sy; return sp[31:0];
      end
      default: begin
        if (y == 32'd0) return x;
        up = ux % uy; return up[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input muldiv_fn_t f, input logic [31:0] x, input logic [31:0] y);
    logic signed_div;
    signed_div = (f == MD_DIV) || (f == MD_REM);
    if (f[2] && (y == 32'd0 || (signed_div && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
      return 1;
    return 34;
  endfunction

  // Scoreboard: push on accepted start, pop and compare on done
  always @(negedge clk) begin : mon
    sb_t e;
    if (reset) begin
      sbq.delete();
    end else begin
      if (bus.done) begin
        n_done++;
        done_cycs.push_back(cyc);
        check("busy during done", 32'(bus.busy), 32'd1);
        if (sbq.size() == 0) begin
          check("unexpected done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("result", bus.r, e.exp);
          check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].start_cyc) begin
        check("busy while running", 32'(bus.busy), 32'd1);
      end
      if (bus.start && !bus.busy) begin
        sbq.push_back('{exp: cur_exp, lat: cur_lat, start_cyc: cyc});
      end
    end
  end

  task automatic apply(input muldiv_fn_t f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) check("idle before start", 32'(bus.busy), 32'd0);
    cur_exp   = exp;
    cur_lat   = lat;
    bus.fn    = f;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || bus.busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: %0d outstanding, busy=%0d", sbq.size(), bus.busy);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          base;
    int          dq;
    muldiv_fn_t  f;
    logic [31:0] x, y;

    bus.start = 1'b0;
    bus.fn    = MD_MUL;
    bus.a     = '0;
    bus.b     = '0;

    vecs.push_back('{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    vecs.push_back('{MD_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 34});
    vecs.push_back('{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    vecs.push_back('{MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
    vecs.push_back('{MD_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34});
    vecs.push_back('{MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
    vecs.push_back('{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
    vecs.push_back('{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
    vecs.push_back('{MD_DIV,    32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         34});
    vecs.push_back('{MD_REM,    32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 34});
    vecs.push_back('{MD_DIV,    32'h8000_0000,  32'd2,         32'hC000_0000, 34});
    vecs.push_back('{MD_DIVU,   32'd100,        32'd7,         32'd14,        34});
    vecs.push_back('{MD_REMU,   32'd100,        32'd7,         32'd2,         34});
    vecs.push_back('{MD_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34});
    vecs.push_back('{MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{MD_REM,    32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{MD_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{MD_REMU,   32'd9,          32'd0,         32'd9,         1});
    vecs.push_back('{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset r", bus.r, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      wait_idle();
    end

    // Random operations against the model
    for (int i = 0; i < 16; i++) begin
      f = muldiv_fn_t'(3'($urandom_range(0, 7)));
      x = $urandom;
      y = (i % 5 == 0) ? 32'd0 : $urandom;
      if (i % 6 == 2) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end
      apply(f, x, y, ref_op(f, x, y), ref_lat(f, x, y));
      wait_idle();
    end

    // Start while busy must be ignored
    apply(MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    repeat (5) @(posedge clk);
    #1;
    bus.fn = MD_DIV; bus.a = 32'd5; bus.b = 32'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();

    // Start held high for 40 cycles: back-to-back acceptance every 35 cycles
    base = n_done;
    dq   = done_cycs.size();
    @(posedge clk); #1;
    cur_exp = 32'd14; cur_lat = 34;
    bus.fn = MD_DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();
    check("handshake done count", 32'(n_done - base), 32'd2);
    if (done_cycs.size() >= dq + 2)
      check("done spacing", 32'(done_cycs[dq+1] - done_cycs[dq]), 32'd35);

    // Reset in the middle of a divide abandons it
    apply(MD_DIVU, 32'd100, 32'd7, 32'd14, 34);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid reset busy", 32'(bus.busy), 32'd0);
    check("mid reset done", 32'(bus.done), 32'd0);
    check("mid reset r", bus.r, 32'd0);
    base = n_done;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("no done after reset", 32'(n_done - base), 32'd0);

    // Fresh operation after the reset completes normally
    apply(MD_REMU, 32'd100, 32'd7, 32'd2, 34);
    wait_idle();
    check("final r hold", bus.r, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
